// File: rtl/axis_fifo_rd_port.sv
// Read-side AXI-Stream master for the async FIFO core. Prefetches core words
// into a two-entry registered buffer so tdata/tvalid come straight from flops
// and fifo_ren never depends on tready. Optional fixed-length tlast framing.
module axis_fifo_rd_port #(
  parameter int DW      = 8,
  parameter int PKT_LEN = 0,
  parameter int CW      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rdata,
  output logic          fifo_ren,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tlast,
  output logic [1:0]    level
);

  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_t;

  localparam logic [CW-1:0] LAST_BEAT = CW'((PKT_LEN > 1) ? (PKT_LEN - 1) : 0);

  occ_t          occ;
  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic [CW-1:0] beat;
  logic          push;
  logic          pop;
  logic          beat_last;

  // Pop request depends only on reset, core flag and registered occupancy.
  assign fifo_ren      = ~rst & ~fifo_empty & (occ != OCC2);
  assign push          = fifo_ren;
  assign m_axis_tvalid = (occ != OCC0);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = e0;
  assign level         = occ;
  assign beat_last     = (beat == LAST_BEAT);

  // For PKT_LEN < 2 beat never leaves 0, so only the PKT_LEN selector matters.
  assign m_axis_tlast  = (PKT_LEN == 0) ? 1'b0 :
                         (PKT_LEN == 1) ? m_axis_tvalid :
                                          (m_axis_tvalid & beat_last);

  // Occupancy and buffer data movement; e0 is always the head beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= OCC0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == OCC0) begin
            e0  <= fifo_rdata;
            occ <= OCC1;
          end else begin
            e1  <= fifo_rdata;
            occ <= OCC2;
          end
        end
        2'b01: begin
          if (occ == OCC2) begin
            e0  <= e1;
            occ <= OCC1;
          end else begin
            occ <= OCC0;
          end
        end
        // Simultaneous push/pop only happens at OCC1: head is replaced in place.
        2'b11: e0 <= fifo_rdata;
        default: ;
      endcase
    end
  end

  // Beat-within-packet counter, advanced by each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
    end else if (pop && (PKT_LEN > 1)) begin
      beat <= beat_last ? '0 : beat + 1'b1;
    end
  end

endmodule
